// File: rtl/spi_slave.sv
// SPI slave endpoint sharing the master's system clock: captures one DATALEN-bit
// word LSB first from MOSI while returning a preloaded word MSB first on MISO.
module spi_slave #(
    parameter int DATALEN = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    input  logic [DATALEN-1:0] txData,
    input  logic               txLoad,
    output logic               txBusy,
    output logic [DATALEN-1:0] rxData,
    output logic               rxValid,
    input  logic               rxAck,
    output logic               rxOverrun,
    output logic               frameAbort
);

    localparam int CW = $clog2(DATALEN + 1);
    localparam int IW = (DATALEN > 1) ? $clog2(DATALEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATALEN - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATALEN - 1);

    typedef enum logic [1:0] {IDLE, SELECT, SHIFT, HOLD} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      bit_idx;
    logic [DATALEN-1:0] rx_shift;
    logic [DATALEN-1:0] rx_next;
    logic [DATALEN-1:0] tx_reg;
    logic               last_bit;

    assign bit_idx  = cnt[IW-1:0];
    assign last_bit = (cnt == LAST_CNT);
    assign txBusy   = (state != IDLE);

    // Received word as it stands after this cycle's MOSI bit lands; also the
    // value handed to rxData on the completing edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_next          = rx_shift;
        rx_next[bit_idx] = MOSI;
    end

    always_comb begin
        MISO = 1'b0;
        case (state)
            SELECT:  MISO = tx_reg[DATALEN-1];
            SHIFT:   MISO = tx_reg[LAST_IDX - bit_idx];
            default: MISO = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_shift   <= '0;
            tx_reg     <= '0;
            rxData     <= '0;
            rxValid    <= 1'b0;
            rxOverrun  <= 1'b0;
            frameAbort <= 1'b0;
        end else begin
            frameAbort <= 1'b0;
            if (rxAck) rxValid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (txLoad) tx_reg <= txData;
                    if (!SS_n) state <= SELECT;
                end
                SELECT: begin
                    cnt <= '0;
                    if (SS_n) begin
                        state      <= IDLE;
                        frameAbort <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (SS_n) begin
                        state      <= IDLE;
                        frameAbort <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        rx_shift <= rx_next;
                        cnt      <= cnt + CW'(1);
                        if (last_bit) begin
                            // A completing frame overrides a same-cycle rxAck.
                            rxData    <= rx_next;
                            rxValid   <= 1'b1;
                            rxOverrun <= rxOverrun | (rxValid & ~rxAck);
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (SS_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: frames, abort, overrun, tx load
// blocking, overlong select and asynchronous reset mid-frame.
module tb_spi_slave;

    localparam int DATALEN = 64;
    localparam logic [63:0] TX0 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] W1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WAB = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] W2  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W3  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] W4  = 64'h8000_0000_0000_0001;
    localparam logic [63:0] W5  = 64'h0000_1111_2222_3333;
    localparam logic [63:0] W6  = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] TXD = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] W7  = 64'h5555_AAAA_3C3C_C3C3;
    localparam logic [63:0] W8  = 64'h7654_3210_FEDC_BA98;

    logic               clock;
    logic               reset_n;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [DATALEN-1:0] txData;
    logic               txLoad;
    logic               txBusy;
    logic [DATALEN-1:0] rxData;
    logic               rxValid;
    logic               rxAck;
    logic               rxOverrun;
    logic               frameAbort;

    int errors = 0;
    int checks = 0;

    logic [63:0] miso_seen;
    int          valid_at;
    int          rises;
    int          late_miso;

    spi_slave #(.DATALEN(DATALEN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .txData     (txData),
        .txLoad     (txLoad),
        .txBusy     (txBusy),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxAck      (rxAck),
        .rxOverrun  (rxOverrun),
        .frameAbort (frameAbort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds SS_n low for low_edges rising edges (edge 1 enters SELECT, edges 3..66
    // carry bits 0..63), then releases SS_n for one edge. The master side shifts
    // MISO left into miso_seen before each data edge.
    task automatic run_frame(input logic [63:0] word, input int low_edges,
                             input int load_edge, input logic [63:0] load_word,
                             input int ack_edge);
        logic prev;
        miso_seen = '0;
        valid_at  = -1;
        rises     = 0;
        late_miso = 0;
        prev      = rxValid;
        SS_n      = 1'b0;
        for (int e = 1; e <= low_edges; e++) begin
            if (e >= 3 && e <= 66) begin
                MOSI      = word[e-3];
                miso_seen = {miso_seen[62:0], MISO};
            end else begin
                MOSI = e[0];
                if (e > 66 && MISO !== 1'b0) late_miso++;
            end
            txLoad = (e == load_edge);
            txData = load_word;
            rxAck  = (e == ack_edge);
            tick();
            txLoad = 1'b0;
            rxAck  = 1'b0;
            if (rxValid && !prev) begin
                rises++;
                if (valid_at < 0) valid_at = e - 1;
            end
            prev = rxValid;
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic pulse_ack();
        rxAck = 1'b1;
        tick();
        rxAck = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        SS_n    = 1'b1;
        MOSI    = 1'b0;
        txData  = '0;
        txLoad  = 1'b0;
        rxAck   = 1'b0;
        repeat (3) tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL reset_rxValid: got %b expected 0", rxValid); end
        checks++; if (rxOverrun !== 1'b0) begin errors++; $display("FAIL reset_rxOverrun: got %b expected 0", rxOverrun); end
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL reset_frameAbort: got %b expected 0", frameAbort); end
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL reset_txBusy: got %b expected 0", txBusy); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_MISO: got %b expected 0", MISO); end
        checks++; if (rxData !== 64'h0) begin errors++; $display("FAIL reset_rxData: got %h expected 0", rxData); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        txData = TX0;
        txLoad = 1'b1;
        tick();
        txLoad = 1'b0;
        SS_n   = 1'b0;
        tick();
        checks++; if (txBusy !== 1'b1) begin errors++; $display("FAIL select_txBusy: got %b expected 1", txBusy); end
        checks++; if (MISO !== TX0[63]) begin errors++; $display("FAIL select_MISO: got %b expected %b", MISO, TX0[63]); end
        SS_n = 1'b1;
        tick();
        checks++; if (frameAbort !== 1'b1) begin errors++; $display("FAIL select_abort: got %b expected 1", frameAbort); end
        tick();
        run_frame(W1, 66, 0, '0, 0);
        checks++; if (rxData !== W1) begin errors++; $display("FAIL basic_rxData: got %h expected %h", rxData, W1); end
        checks++; if (valid_at !== 65) begin errors++; $display("FAIL basic_latency: got %0d expected 65", valid_at); end
        checks++; if (miso_seen !== TX0) begin errors++; $display("FAIL basic_miso: got %h expected %h", miso_seen, TX0); end
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL basic_rxValid: got %b expected 1", rxValid); end
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL basic_txBusy_idle: got %b expected 0", txBusy); end
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL basic_no_abort: got %b expected 0", frameAbort); end
    endtask

    task automatic test_abort();
        pulse_ack();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL ack_clears_valid: got %b expected 0", rxValid); end
        run_frame(WAB, 12, 0, '0, 0);
        checks++; if (frameAbort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", frameAbort); end
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL abort_rxValid: got %b expected 0", rxValid); end
        checks++; if (rxData !== W1) begin errors++; $display("FAIL abort_rxData: got %h expected %h", rxData, W1); end
        tick();
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b expected 0", frameAbort); end
        run_frame(W2, 66, 0, '0, 0);
        checks++; if (rxData !== W2) begin errors++; $display("FAIL after_abort_rxData: got %h expected %h", rxData, W2); end
        checks++; if (rxOverrun !== 1'b0) begin errors++; $display("FAIL after_abort_overrun: got %b expected 0", rxOverrun); end
    endtask

    task automatic test_ack_on_completion();
        run_frame(W3, 66, 0, '0, 66);
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL ack_same_edge_valid: got %b expected 1", rxValid); end
        checks++; if (rxOverrun !== 1'b0) begin errors++; $display("FAIL ack_same_edge_overrun: got %b expected 0", rxOverrun); end
        checks++; if (rxData !== W3) begin errors++; $display("FAIL ack_same_edge_rxData: got %h expected %h", rxData, W3); end
    endtask

    task automatic test_overrun();
        run_frame(W4, 66, 0, '0, 0);
        checks++; if (rxData !== W4) begin errors++; $display("FAIL overrun_rxData: got %h expected %h", rxData, W4); end
        checks++; if (rxOverrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", rxOverrun); end
        pulse_ack();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL overrun_ack_valid: got %b expected 0", rxValid); end
        checks++; if (rxOverrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", rxOverrun); end
    endtask

    task automatic test_blocked_load();
        run_frame(W5, 66, 20, TXD, 0);
        checks++; if (miso_seen !== TX0) begin errors++; $display("FAIL blocked_load_miso: got %h expected %h", miso_seen, TX0); end
        checks++; if (rxData !== W5) begin errors++; $display("FAIL blocked_load_rxData: got %h expected %h", rxData, W5); end
        run_frame(W6, 66, 0, '0, 0);
        checks++; if (miso_seen !== TX0) begin errors++; $display("FAIL resend_old_tx: got %h expected %h", miso_seen, TX0); end
        txData = TXD;
        txLoad = 1'b1;
        tick();
        txLoad = 1'b0;
        run_frame(W6, 66, 0, '0, 0);
        checks++; if (miso_seen !== TXD) begin errors++; $display("FAIL idle_load_miso: got %h expected %h", miso_seen, TXD); end
    endtask

    task automatic test_overlong_select();
        pulse_ack();
        run_frame(W7, 80, 0, '0, 0);
        checks++; if (rises !== 1) begin errors++; $display("FAIL overlong_valid_rises: got %0d expected 1", rises); end
        checks++; if (valid_at !== 65) begin errors++; $display("FAIL overlong_latency: got %0d expected 65", valid_at); end
        checks++; if (late_miso !== 0) begin errors++; $display("FAIL overlong_miso_hold: got %0d nonzero bits expected 0", late_miso); end
        checks++; if (rxData !== W7) begin errors++; $display("FAIL overlong_rxData: got %h expected %h", rxData, W7); end
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL overlong_no_abort: got %b expected 0", frameAbort); end
    endtask

    task automatic test_reset_mid_shift();
        SS_n = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            MOSI = 1'b1;
            tick();
        end
        checks++; if (txBusy !== 1'b1) begin errors++; $display("FAIL mid_shift_busy: got %b expected 1", txBusy); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL async_rst_rxValid: got %b expected 0", rxValid); end
        checks++; if (rxOverrun !== 1'b0) begin errors++; $display("FAIL async_rst_overrun: got %b expected 0", rxOverrun); end
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL async_rst_txBusy: got %b expected 0", txBusy); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL async_rst_MISO: got %b expected 0", MISO); end
        checks++; if (rxData !== 64'h0) begin errors++; $display("FAIL async_rst_rxData: got %h expected 0", rxData); end
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL async_rst_abort: got %b expected 0", frameAbort); end
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++; if (frameAbort !== 1'b0) begin errors++; $display("FAIL post_rst_abort: got %b expected 0", frameAbort); end
        run_frame(W8, 66, 0, '0, 0);
        checks++; if (miso_seen !== 64'h0) begin errors++; $display("FAIL post_rst_tx_cleared: got %h expected 0", miso_seen); end
        checks++; if (rxData !== W8) begin errors++; $display("FAIL post_rst_rxData: got %h expected %h", rxData, W8); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_abort();
        test_ack_on_completion();
        test_overrun();
        test_blocked_load();
        test_overlong_select();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
